// File: rtl/rat_pkg.sv
// rat_pkg: shared move encodings, FSM state enum and default coordinate width for the maze solver
package rat_pkg;
  localparam int DEF_CW = 4;
  localparam logic [1:0] MV_UP    = 2'b00;
  localparam logic [1:0] MV_RIGHT = 2'b01;
  localparam logic [1:0] MV_LEFT  = 2'b10;
  localparam logic [1:0] MV_DOWN  = 2'b11;
  typedef enum logic [2:0] {IDLE, MARK, GOAL, TRY, POP, DONE, PLAY, FAIL} state_e;
endpackage

// File: rtl/maze_ram.sv
// maze_ram: 2^CW x 2^CW bit maze; combinational read (d_out) while rd, registered write of d_in at (x,y), row load port ld/ld_y/ld_row
module maze_ram #(
  parameter int CW = 4
) (
  input  logic              clk,
  input  logic [CW-1:0]     x,
  input  logic [CW-1:0]     y,
  input  logic              rd,
  input  logic              wr,
  input  logic              d_in,
  output logic              d_out,
  input  logic              ld,
  input  logic [CW-1:0]     ld_y,
  input  logic [2**CW-1:0]  ld_row
);
  logic [2**CW-1:0] mem_q [2**CW];
  assign d_out = rd & mem_q[y][x];
  always_ff @(posedge clk) begin
    if (wr) mem_q[y][x] <= d_in;
    else if (ld) mem_q[ld_y] <= ld_row;
  end
endmodule

// File: rtl/rat_move_stack.sv
// rat_move_stack: DEPTH x 2-bit move stack; push/pop at sp, top = stack[sp-1], rd_idx/rd_dir replay read port
module rat_move_stack #(
  parameter int DEPTH = 256,
  parameter int SW    = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic                 pop,
  input  logic [1:0]           push_dir,
  input  logic [SW-2:0]        rd_idx,
  output logic [SW-1:0]        sp,
  output logic [1:0]           top,
  output logic [1:0]           rd_dir
);
  localparam int AW = SW - 1;
  logic [1:0]    mem_q [DEPTH];
  logic [SW-1:0] sp_q, sp_d;
  logic [AW-1:0] top_idx;
  always_comb sp_d = push ? sp_q + SW'(1) : pop ? sp_q - SW'(1) : sp_q;
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else sp_q <= sp_d;
    if (push) mem_q[sp_q[AW-1:0]] <= push_dir;
  end
  assign top_idx = sp_q[AW-1:0] - AW'(1);
  assign sp      = sp_q;
  assign top     = mem_q[top_idx];
  assign rd_dir  = mem_q[rd_idx];
endmodule

// File: rtl/rat_maze_solver.sv
// rat_maze_solver: DFS maze solver; Start/Run in, Done/Fail/Move out, X/Y/RD/WR/D_in/D_out to the maze memory
module rat_maze_solver
  import rat_pkg::*;
#(
  parameter int CW     = DEF_CW,
  parameter int GOAL_X = 15,
  parameter int GOAL_Y = 15,
  parameter int DEPTH  = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          Start,
  input  logic          Run,
  output logic          Fail,
  output logic          Done,
  output logic [1:0]    Move,
  output logic [CW-1:0] X,
  output logic [CW-1:0] Y,
  output logic          D_in,
  input  logic          D_out,
  output logic          RD,
  output logic          WR
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = AW + 1;
  localparam logic [CW-1:0] MAXC = '1;
  state_e        state_q, state_d;
  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d, x_q, x_d, y_q, y_d;
  logic [1:0]    dir_q, dir_d, move_q, move_d, top, rd_dir;
  logic [SW-1:0] i_q, i_d, sp;
  logic          rd_q, rd_d, wr_q, wr_d, done_q, done_d, fail_q, fail_d, push, pop;

  function automatic logic off_grid(input logic [CW-1:0] cx, input logic [CW-1:0] cy, input logic [1:0] d);
    return d == MV_UP ? cy == '0 : d == MV_RIGHT ? cx == MAXC : d == MV_LEFT ? cx == '0 : cy == MAXC;
  endfunction

  function automatic logic [CW-1:0] step_x(input logic [CW-1:0] cx, input logic [1:0] d);
    return d == MV_RIGHT ? cx + CW'(1) : d == MV_LEFT ? cx - CW'(1) : cx;
  endfunction

  function automatic logic [CW-1:0] step_y(input logic [CW-1:0] cy, input logic [1:0] d);
    return d == MV_DOWN ? cy + CW'(1) : d == MV_UP ? cy - CW'(1) : cy;
  endfunction

  rat_move_stack #(.DEPTH(DEPTH), .SW(SW)) u_stack (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .push_dir (dir_q),
    .rd_idx   (i_d[AW-1:0]),
    .sp       (sp),
    .top      (top),
    .rd_dir   (rd_dir)
  );

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    dir_d   = dir_q;
    i_d     = i_q;
    push    = 1'b0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (Start) begin
        state_d = MARK;
        cx_d    = '0;
        cy_d    = '0;
        dir_d   = MV_UP;
      end
      MARK: state_d = GOAL;
      GOAL: begin
        state_d = (cx_q == CW'(GOAL_X) && cy_q == CW'(GOAL_Y)) ? DONE : TRY;
        dir_d   = MV_UP;
      end
      TRY: if (!off_grid(cx_q, cy_q, dir_q) && !D_out) begin
        push    = 1'b1;
        cx_d    = step_x(cx_q, dir_q);
        cy_d    = step_y(cy_q, dir_q);
        state_d = MARK;
      end else if (dir_q != MV_DOWN) dir_d = dir_q + 2'd1;
      else state_d = POP;
      // Undo the popped move (~d is its opposite) and resume at the direction after it.
      POP: if (sp == '0) state_d = FAIL;
      else begin
        pop     = 1'b1;
        cx_d    = step_x(cx_q, ~top);
        cy_d    = step_y(cy_q, ~top);
        dir_d   = top + 2'd1;
        state_d = top == MV_DOWN ? POP : TRY;
      end
      DONE: if (Run) begin
        i_d     = '0;
        state_d = sp == '0 ? DONE : PLAY;
      end
      PLAY: begin
        i_d     = i_q + SW'(1);
        state_d = i_q == sp - SW'(1) ? DONE : PLAY;
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so a TRY probe address is on X/Y/RD during that TRY cycle.
  always_comb begin
    rd_d   = state_d == TRY && !off_grid(cx_d, cy_d, dir_d);
    x_d    = rd_d ? step_x(cx_d, dir_d) : cx_d;
    y_d    = rd_d ? step_y(cy_d, dir_d) : cy_d;
    wr_d   = state_d == MARK;
    done_d = state_d == DONE || state_d == PLAY;
    fail_d = state_d == FAIL;
    move_d = state_d == PLAY ? rd_dir : MV_UP;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      dir_q   <= MV_UP;
      i_q     <= '0;
      x_q     <= '0;
      y_q     <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      move_q  <= MV_UP;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      dir_q   <= dir_d;
      i_q     <= i_d;
      x_q     <= x_d;
      y_q     <= y_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      move_q  <= move_d;
    end
  end

  assign X    = x_q;
  assign Y    = y_q;
  assign RD   = rd_q;
  assign WR   = wr_q;
  assign D_in = wr_q;
  assign Done = done_q;
  assign Fail = fail_q;
  assign Move = move_q;
endmodule

// File: tb/tb_rat_maze_solver.sv
// tb_rat_maze_solver: scoreboard bench for rat_maze_solver with a maze_ram alongside
module tb_rat_maze_solver;
  import rat_pkg::*;
  logic        clk = 1'b0, rst = 1'b1, start = 1'b0, run = 1'b0, ld = 1'b0;
  logic        fail, done, d_in, d_out, rd, wr;
  logic [1:0]  move;
  logic [3:0]  x, y, ld_y = '0;
  logic [15:0] ld_row = '0;
  logic [15:0] maze [16];
  logic [1:0]  exp_q [$];
  int          checks = 0, errors = 0, pops;

  always #5 clk = ~clk;

  rat_maze_solver #(.CW(4), .GOAL_X(15), .GOAL_Y(15), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .Start(start), .Run(run), .Fail(fail), .Done(done), .Move(move),
    .X(x), .Y(y), .D_in(d_in), .D_out(d_out), .RD(rd), .WR(wr)
  );

  maze_ram #(.CW(4)) u_ram (
    .clk(clk), .x(x), .y(y), .rd(rd), .wr(wr), .d_in(d_in), .d_out(d_out),
    .ld(ld), .ld_y(ld_y), .ld_row(ld_row)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, act, exp);
    end
  endtask

  task automatic reset_load();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 0; r < 16; r++) begin
      ld = 1'b1; ld_y = 4'(r); ld_row = maze[r];
      @(posedge clk);
      #1;
    end
    ld = 1'b0;
    rst = 1'b0;
  endtask

  task automatic wait_end(output int np);
    int n = 0;
    np = 0;
    while (!(done || fail) && n < 20000) begin
      @(negedge clk);
      n++;
      if (dut.state_q == POP) np++;
    end
    chk("search_bound", n < 20000, 1);
  endtask

  task automatic search(output int np);
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_end(np);
  endtask

  task automatic replay();
    int n = exp_q.size();
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("move", move, exp_q.pop_front());
    end
    @(negedge clk);
    chk("move_end", move, MV_UP);
    chk("replay_done", dut.state_q == DONE, 1);
    chk("done_hold", done, 1);
  endtask

  initial begin
    // Open maze: DFS order up,right,left,down snakes across rows 0..14 then drops onto the goal.
    for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
    reset_load();
    @(negedge clk);
    chk("rst_outs", {done, fail, move, x, y, rd, wr, d_in}, 0);
    chk("rst_state", dut.state_q == IDLE, 1);
    for (int r = 0; r < 15; r++) begin
      for (int k = 0; k < 15; k++) exp_q.push_back(r % 2 == 0 ? MV_RIGHT : MV_LEFT);
      exp_q.push_back(MV_DOWN);
    end
    search(pops);
    chk("open_done", done, 1);
    chk("open_fail", fail, 0);
    chk("open_pops", pops, 0);
    replay();

    // Row-0 corridor with a 3-cell dead end past column 5, then column 5 down and row 15 right.
    maze[0] = 16'hFE00;
    for (int r = 1; r < 15; r++) maze[r] = 16'hFFDF;
    maze[15] = 16'h001F;
    reset_load();
    for (int k = 0; k < 5; k++) exp_q.push_back(MV_RIGHT);
    for (int k = 0; k < 15; k++) exp_q.push_back(MV_DOWN);
    for (int k = 0; k < 10; k++) exp_q.push_back(MV_RIGHT);
    search(pops);
    chk("corr_done", done, 1);
    chk("corr_fail", fail, 0);
    chk("corr_pops", pops, 3);
    replay();

    // Goal isolated by walls on both neighbours: exhaustive search must fail and ignore Run.
    for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
    maze[14] = 16'h8000;
    maze[15] = 16'h4000;
    reset_load();
    search(pops);
    chk("iso_fail", fail, 1);
    chk("iso_done", done, 0);
    run = 1'b1;
    repeat (3) @(negedge clk);
    run = 1'b0;
    chk("iso_run_state", dut.state_q == FAIL, 1);
    chk("iso_run_outs", {done, fail, move, rd, wr}, 6'b01_00_00);

    // Column 0 down then row 15 right; Start held 3 cycles; probes at (0,0) checked per cycle.
    for (int r = 0; r < 15; r++) maze[r] = 16'hFFFE;
    maze[15] = 16'h0000;
    reset_load();
    for (int k = 0; k < 15; k++) exp_q.push_back(MV_DOWN);
    for (int k = 0; k < 15; k++) exp_q.push_back(MV_RIGHT);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("b_mark", {wr, d_in, x, y}, {2'b11, 8'h00});
    @(negedge clk);
    chk("b_goal", {rd, wr}, 0);
    @(negedge clk);
    start = 1'b0;
    chk("b_up", {rd, x, y}, {1'b0, 8'h00});
    @(negedge clk);
    chk("b_right", {rd, x, y}, {1'b1, 8'h10});
    @(negedge clk);
    chk("b_left", {rd, x, y}, {1'b0, 8'h00});
    @(negedge clk);
    chk("b_down", {rd, x, y}, {1'b1, 8'h01});
    @(negedge clk);
    chk("b_mark2", {wr, x, y}, {1'b1, 8'h01});
    wait_end(pops);
    chk("col_done", done, 1);
    start = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("start_in_done", {done, wr, rd}, 3'b100);
    end
    start = 1'b0;
    replay();

    // Reset mid-search.
    for (int r = 0; r < 16; r++) maze[r] = 16'h0000;
    reset_load();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_search_outs", {done, fail, move, x, y, rd, wr, d_in}, 0);
    chk("rst_search_state", dut.state_q == IDLE, 1);
    rst = 1'b0;

    // Reset mid-replay.
    reset_load();
    search(pops);
    chk("rr_done", done, 1);
    @(posedge clk);
    #1 run = 1'b1;
    @(posedge clk);
    #1 run = 1'b0;
    repeat (10) @(negedge clk);
    chk("rr_playing", dut.state_q == PLAY, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_play_outs", {done, fail, move, x, y, rd, wr, d_in}, 0);
    chk("rst_play_state", dut.state_q == IDLE, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_rst", {done, fail, wr, rd}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
